mipsfpga_display_axi4_burst_slave: RTL and testbench

Parametrised AXI4 full-protocol slave for the mipsfpga_display IP. It holds a word-addressed register/pixel memory and supports FIXED, INCR and WRAP bursts up to 256 beats, with byte strobes, ID echo and SLVERR reporting. Independent write and read engines let a display master and the MIPS core stream bursts concurrently.

---
 rtl/mipsfpga_display_axi_pkg.sv | 35 +++
 rtl/mipsfpga_display_axi_addr_gen.sv | 37 +++
 rtl/mipsfpga_display_axi4_burst_slave.sv | 232 +++++++++++++++++++++++
 tb/tb_mipsfpga_display_axi4_burst_slave.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipsfpga_display_axi_pkg.sv
// Shared encodings for the mipsfpga_display AXI4 burst slave: burst types,
// response codes, engine state encodings and a constant log2 helper.
package mipsfpga_display_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/mipsfpga_display_axi_addr_gen.sv
// Word-index sequencer for one AXI channel: next beat index, out-of-range
// flag and illegal-burst flag for the beat at the current index.
module mipsfpga_display_axi_addr_gen
    import mipsfpga_display_axi_pkg::*;
#(
    parameter int IDX_W = 30,
    parameter int DEPTH = 256
) (
    input  logic [IDX_W-1:0] index,
    input  logic [7:0]       len,
    input  logic [1:0]       burst,
    output logic [IDX_W-1:0] next_index,
    output logic             out_of_range,
    output logic             burst_err
);

    logic             wrap_len_ok;
    logic [IDX_W-1:0] mask;
    logic [IDX_W-1:0] incr;

    assign wrap_len_ok  = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    assign mask         = IDX_W'(len);
    assign incr         = index + IDX_W'(1);
    assign out_of_range = (64'(index) >= 64'(DEPTH));

    // Illegal WRAP lengths and the reserved type fall back to INCR stepping.
    always_comb begin
        burst_err  = (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok);
        next_index = incr;
        if (burst == BURST_FIXED) begin
            next_index = index;
        end else if ((burst == BURST_WRAP) && wrap_len_ok) begin
            next_index = (index & ~mask) | (incr & mask);
        end
    end

endmodule

// File: rtl/mipsfpga_display_axi4_burst_slave.sv
// AXI4 burst slave over a word-addressed memory with independent write and
// read engines (FIXED/INCR/WRAP, byte strobes, ID echo, SLVERR reporting).
module mipsfpga_display_axi4_burst_slave
    import mipsfpga_display_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_ID_WIDTH   = 4,
    parameter int C_MEM_DEPTH        = 256
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_awid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [7:0]                      s00_axi_awlen,
    input  logic [1:0]                      s00_axi_awburst,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wlast,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_bid,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_arid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [7:0]                      s00_axi_arlen,
    input  logic [1:0]                      s00_axi_arburst,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_rid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rlast,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int IW    = C_S_AXI_ID_WIDTH;
    localparam int B     = DW / 8;
    localparam int LB    = clog2(B);
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - LB;
    localparam int MW    = clog2(C_MEM_DEPTH);

    logic [DW-1:0] mem [C_MEM_DEPTH];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{s00_axi_awaddr[LB-1:0], s00_axi_araddr[LB-1:0]};

    // ---------------- write engine ----------------
    w_state_t         w_state_reg, w_state_next;
    logic [IW-1:0]    w_id_reg;
    logic [IDX_W-1:0] w_index_reg, w_index_adv;
    logic [7:0]       w_len_reg, w_cnt_reg;
    logic [1:0]       w_burst_reg;
    logic             w_err_reg;
    logic             w_oor, w_burst_err, w_last_beat, w_hs, mem_we;

    mipsfpga_display_axi_addr_gen #(.IDX_W(IDX_W), .DEPTH(C_MEM_DEPTH)) u_w_addr (
        .index        (w_index_reg),
        .len          (w_len_reg),
        .burst        (w_burst_reg),
        .next_index   (w_index_adv),
        .out_of_range (w_oor),
        .burst_err    (w_burst_err)
    );

    assign w_last_beat = (w_cnt_reg == w_len_reg);
    assign w_hs        = (w_state_reg == W_DATA) && s00_axi_wvalid;
    assign mem_we      = w_hs && !w_oor;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) w_state_reg <= W_IDLE;
        else          w_state_reg <= w_state_next;
    end

    always_comb begin
        w_state_next    = w_state_reg;
        s00_axi_awready = 1'b0;
        s00_axi_wready  = 1'b0;
        s00_axi_bvalid  = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                s00_axi_awready = ARESETN;
                if (s00_axi_awvalid) w_state_next = W_DATA;
            end
            W_DATA: begin
                s00_axi_wready = 1'b1;
                if (s00_axi_wvalid && w_last_beat) w_state_next = W_RESP;
            end
            W_RESP: begin
                s00_axi_bvalid = 1'b1;
                if (s00_axi_bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_id_reg    <= '0;
            w_index_reg <= '0;
            w_len_reg   <= '0;
            w_burst_reg <= '0;
            w_cnt_reg   <= '0;
            w_err_reg   <= 1'b0;
        end else if ((w_state_reg == W_IDLE) && s00_axi_awvalid) begin
            w_id_reg    <= s00_axi_awid;
            w_index_reg <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:LB];
            w_len_reg   <= s00_axi_awlen;
            w_burst_reg <= s00_axi_awburst;
            w_cnt_reg   <= '0;
            w_err_reg   <= 1'b0;
        end else if (w_hs) begin
            // A wlast that disagrees with the beat count is flagged, but the
            // burst still ends on the count.
            w_index_reg <= w_index_adv;
            w_cnt_reg   <= w_cnt_reg + 8'd1;
            w_err_reg   <= w_err_reg | w_oor | w_burst_err | (s00_axi_wlast != w_last_beat);
        end
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < B; b++) begin
                if (s00_axi_wstrb[b]) mem[w_index_reg[MW-1:0]][b*8 +: 8] <= s00_axi_wdata[b*8 +: 8];
            end
        end
    end

    assign s00_axi_bid   = w_id_reg;
    assign s00_axi_bresp = ((w_state_reg == W_RESP) && w_err_reg) ? RESP_SLVERR : RESP_OKAY;

    // ---------------- read engine ----------------
    r_state_t         r_state_reg, r_state_next;
    logic [IW-1:0]    r_id_reg;
    logic [IDX_W-1:0] r_index_reg, r_gen_index, r_index_adv;
    logic [7:0]       r_len_reg, r_cnt_reg, r_gen_len;
    logic [1:0]       r_burst_reg, r_gen_burst;
    logic             r_oor, r_burst_err, r_last_beat, ar_hs, r_hs, r_load;
    logic [DW-1:0]    rdata_mem_reg;
    logic             rdata_zero_reg;
    logic [1:0]       rresp_reg;
    logic             rlast_reg;

    // The generator serves the AR address while idle and the stored next
    // index during a burst, so the first beat loads straight off the handshake.
    assign r_gen_index = (r_state_reg == R_IDLE) ? s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:LB] : r_index_reg;
    assign r_gen_len   = (r_state_reg == R_IDLE) ? s00_axi_arlen   : r_len_reg;
    assign r_gen_burst = (r_state_reg == R_IDLE) ? s00_axi_arburst : r_burst_reg;

    mipsfpga_display_axi_addr_gen #(.IDX_W(IDX_W), .DEPTH(C_MEM_DEPTH)) u_r_addr (
        .index        (r_gen_index),
        .len          (r_gen_len),
        .burst        (r_gen_burst),
        .next_index   (r_index_adv),
        .out_of_range (r_oor),
        .burst_err    (r_burst_err)
    );

    assign r_last_beat = (r_cnt_reg == r_len_reg);
    assign ar_hs       = (r_state_reg == R_IDLE) && s00_axi_arvalid;
    assign r_hs        = (r_state_reg == R_DATA) && s00_axi_rready;
    assign r_load      = ar_hs || (r_hs && !r_last_beat);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state_reg <= R_IDLE;
        else          r_state_reg <= r_state_next;
    end

    always_comb begin
        r_state_next    = r_state_reg;
        s00_axi_arready = 1'b0;
        s00_axi_rvalid  = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                s00_axi_arready = ARESETN;
                if (s00_axi_arvalid) r_state_next = R_DATA;
            end
            R_DATA: begin
                s00_axi_rvalid = 1'b1;
                if (s00_axi_rready && r_last_beat) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_id_reg       <= '0;
            r_index_reg    <= '0;
            r_len_reg      <= '0;
            r_burst_reg    <= '0;
            r_cnt_reg      <= '0;
            rdata_zero_reg <= 1'b1;
            rresp_reg      <= RESP_OKAY;
            rlast_reg      <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_id_reg    <= s00_axi_arid;
                r_len_reg   <= s00_axi_arlen;
                r_burst_reg <= s00_axi_arburst;
                r_cnt_reg   <= '0;
                rlast_reg   <= (s00_axi_arlen == 8'd0);
            end else if (r_load) begin
                r_cnt_reg   <= r_cnt_reg + 8'd1;
                rlast_reg   <= ((r_cnt_reg + 8'd1) == r_len_reg);
            end
            if (r_load) begin
                r_index_reg    <= r_index_adv;
                rdata_zero_reg <= r_oor;
                rresp_reg      <= (r_oor || r_burst_err) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Plain registered read keeps the array mappable to block RAM; zeroing
    // for reset and out-of-range beats is applied on the output side.
    always_ff @(posedge ACLK) begin
        if (r_load) rdata_mem_reg <= mem[r_gen_index[MW-1:0]];
    end

    assign s00_axi_rid   = r_id_reg;
    assign s00_axi_rdata = rdata_zero_reg ? '0 : rdata_mem_reg;
    assign s00_axi_rresp = rresp_reg;
    assign s00_axi_rlast = rlast_reg;

endmodule

// File: tb/tb_mipsfpga_display_axi4_burst_slave.sv
// Directed + randomized bench for the AXI4 burst slave, checked against a
// word-array reference model with arithmetic burst index sequencing.
module tb_mipsfpga_display_axi4_burst_slave;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;
    localparam logic [1:0] RSVD  = 2'b11;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] model_mem [0:255];
    logic [31:0] wr_data [0:255];
    logic [3:0]  wr_strb [0:255];

    always #5 aclk = ~aclk;

    mipsfpga_display_axi4_burst_slave dut (
        .ACLK(aclk), .ARESETN(aresetn),
        .s00_axi_awid(awid), .s00_axi_awaddr(awaddr), .s00_axi_awlen(awlen),
        .s00_axi_awburst(awburst), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wlast(wlast),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bid(bid), .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_arid(arid), .s00_axi_araddr(araddr), .s00_axi_arlen(arlen),
        .s00_axi_arburst(arburst), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rid(rid), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
        .s00_axi_rlast(rlast), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word visited on beat i of a burst starting at word 'start'.
    function automatic int model_idx(input int start, input int len, input logic [1:0] burst, input int i);
        int n;
        int base;
        n = len + 1;
        if (burst == FIXED) return start;
        if (burst == WRAP && (n == 2 || n == 4 || n == 8 || n == 16)) begin
            base = (start / n) * n;
            return base + ((start - base + i) % n);
        end
        return start + i;
    endfunction

    function automatic bit burst_bad(input int len, input logic [1:0] burst);
        return (burst == RSVD) || (burst == WRAP && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    // Starts and ends #1 after a rising edge. abort_beats >= 0 returns with
    // that beat's data presented but not yet accepted.
    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input int bready_delay, input bit bad_wlast,
                             input int abort_beats);
        int start;
        int idx;
        int cyc;
        bit hs;
        bit exp_err;
        logic [1:0] got_resp;
        logic [3:0] got_id;
        start = int'(addr >> 2);
        exp_err = burst_bad(len, burst) || bad_wlast;
        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
        hs = 0; cyc = 0;
        while (!hs && cyc < 200) begin
            hs = awready; @(posedge aclk); #1; cyc++;
        end
        awvalid = 1'b0;
        check("aw_handshake", 64'(hs), 64'd1);
        for (int i = 0; i <= len; i++) begin
            wdata = wr_data[i]; wstrb = wr_strb[i];
            wlast = bad_wlast ? 1'b0 : (i == len);
            wvalid = 1'b1;
            if (i == abort_beats) return;
            hs = 0; cyc = 0;
            while (!hs && cyc < 200) begin
                hs = wready; @(posedge aclk); #1; cyc++;
            end
            if (!hs) check("w_handshake", 64'(hs), 64'd1);
            idx = model_idx(start, len, burst, i);
            if (idx >= 256) exp_err = 1;
            else for (int b = 0; b < 4; b++)
                if (wr_strb[i][b]) model_mem[idx][b*8 +: 8] = wr_data[i][b*8 +: 8];
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
        for (int d = 0; d < bready_delay; d++) begin
            check("b_hold_awready_low", 64'({bvalid, awready}), 64'b10);
            @(posedge aclk); #1;
        end
        bready = 1'b1;
        hs = 0; cyc = 0; got_resp = 2'bxx; got_id = 4'bxxxx;
        while (!hs && cyc < 200) begin
            hs = bvalid; got_resp = bresp; got_id = bid;
            @(posedge aclk); #1; cyc++;
        end
        bready = 1'b0;
        check("b_handshake", 64'(hs), 64'd1);
        check("bresp", 64'(got_resp), exp_err ? 64'b10 : 64'b00);
        check("bid", 64'(got_id), 64'(id));
        $display("write id=%0d addr=%h len=%0d burst=%0d bresp=%0d", id, addr, len, burst, got_resp);
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input bit toggle);
        int start;
        int idx;
        int cyc;
        int i;
        int n_slverr;
        bit hs;
        bit e_err;
        logic [31:0] e_data;
        start = int'(addr >> 2);
        arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
        hs = 0; cyc = 0;
        while (!hs && cyc < 200) begin
            hs = arready; @(posedge aclk); #1; cyc++;
        end
        arvalid = 1'b0;
        check("ar_handshake", 64'(hs), 64'd1);
        if (!hs) return;
        check("rvalid_latency", 64'(rvalid), 64'd1);
        i = 0; cyc = 0; n_slverr = 0;
        while (i <= len && cyc < 2000) begin
            rready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (rvalid) begin
                idx = model_idx(start, len, burst, i);
                e_err = (idx >= 256) || burst_bad(len, burst);
                e_data = (idx >= 256) ? 32'h0 : model_mem[idx];
                check($sformatf("rbeat%0d", i), 64'({rid, rresp, rlast, rdata}),
                      64'({id, e_err ? 2'b10 : 2'b00, (i == len), e_data}));
                if (e_err && rready) n_slverr++;
            end
            hs = rvalid && rready;
            @(posedge aclk); #1; cyc++;
            if (hs) i++;
        end
        rready = 1'b0;
        check("r_beats_done", 64'(i), 64'(len + 1));
        check("rvalid_after_last", 64'(rvalid), 64'd0);
        $display("read  id=%0d addr=%h len=%0d burst=%0d slverr_beats=%0d", id, addr, len, burst, n_slverr);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_w;
        int len_r;
        logic [1:0] burst_r;

        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 32'h0; wr_strb[i] = 4'hF; wr_data[i] = 32'h0;
        end

        repeat (3) @(posedge aclk);
        #1;
        check("reset_outputs_zero", 64'({awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid}), 64'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("idle_readies", 64'({awready, arready, wready, bvalid, rvalid}), 64'b11000);

        // INCR write of 16 words, WRAP read back from word 0 and word 8
        wr_data[0] = 32'h00abcdef;
        for (int i = 1; i < 16; i++) wr_data[i] = 32'h11111111 * i;
        axi_write(4'd2, 32'h0, 15, INCR, 0, 0, -1);
        axi_read(4'd1, 32'h0, 15, WRAP, 0);
        axi_read(4'd2, 32'h20, 15, WRAP, 0);

        // FIXED write lands every beat on one word; then partial strobe
        for (int i = 0; i < 4; i++) wr_data[i] = 32'h11111111 * (i + 1);
        axi_write(4'd1, 32'h10, 3, FIXED, 0, 0, -1);
        axi_read(4'd1, 32'h10, 0, FIXED, 0);
        wr_data[0] = 32'hFFFFFFFF;
        axi_write(4'd1, 32'h10, 0, INCR, 0, 0, -1);
        wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'b0011;
        axi_write(4'd1, 32'h10, 0, INCR, 0, 0, -1);
        wr_strb[0] = 4'hF;
        axi_read(4'd1, 32'h10, 0, INCR, 0);

        // Run off the top of memory: beats 2 and 3 are out of range
        for (int i = 0; i < 4; i++) wr_data[i] = $urandom;
        axi_write(4'd4, 32'h3F8, 3, INCR, 0, 0, -1);
        axi_read(4'd4, 32'h3F8, 3, INCR, 0);

        // wlast missing on the final beat
        for (int i = 0; i < 3; i++) wr_data[i] = $urandom;
        axi_write(4'd6, 32'h300, 2, INCR, 0, 1, -1);
        axi_read(4'd6, 32'h300, 2, INCR, 0);

        // Concurrent AW+AR, slow bready, toggling rready
        for (int i = 0; i < 16; i++) wr_data[i] = $urandom;
        fork
            axi_write(4'd3, 32'h80, 15, INCR, 5, 0, -1);
            axi_read(4'd7, 32'h0, 15, INCR, 1);
        join
        axi_read(4'd3, 32'h80, 15, INCR, 1);

        // Prefill words 64..127, then random bursts inside that region
        for (int i = 0; i < 64; i++) wr_data[i] = $urandom;
        axi_write(4'd0, 32'h100, 63, INCR, 0, 0, -1);
        for (int t = 0; t < 6; t++) begin
            start_w = 64 + $urandom_range(0, 40);
            case ($urandom_range(0, 5))
                0: len_r = 0;
                1: len_r = 1;
                2: len_r = 3;
                3: len_r = 7;
                4: len_r = 15;
                default: len_r = $urandom_range(0, 20);
            endcase
            burst_r = 2'($urandom_range(0, 3));
            for (int i = 0; i <= len_r; i++) begin
                wr_data[i] = $urandom; wr_strb[i] = 4'($urandom_range(1, 15));
            end
            axi_write(4'($urandom), 32'(start_w * 4), len_r, burst_r, $urandom_range(0, 3), 0, -1);
            axi_read(4'($urandom), 32'(start_w * 4), len_r, burst_r, 1'($urandom));
        end
        for (int i = 0; i < 16; i++) wr_strb[i] = 4'hF;

        // Reset during beat 6 of a 16-beat write
        for (int i = 0; i < 16; i++) wr_data[i] = $urandom;
        axi_write(4'd5, 32'h280, 15, INCR, 0, 0, 6);
        #2 aresetn = 1'b0;
        #1;
        check("midburst_reset_outputs_zero", 64'({awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid}), 64'd0);
        wvalid = 1'b0; wlast = 1'b0;
        repeat (2) @(posedge aclk);
        #2 aresetn = 1'b1;
        @(posedge aclk); #1;
        check("post_reset_idle", 64'({awready, arready, wready, bvalid, rvalid}), 64'b11000);
        for (int i = 0; i < 4; i++) wr_data[i] = $urandom;
        axi_write(4'd9, 32'h2C0, 3, INCR, 0, 0, -1);
        axi_read(4'd9, 32'h280, 5, INCR, 0);
        axi_read(4'd8, 32'h2C0, 3, INCR, 0);
        axi_read(4'd1, 32'h0, 15, INCR, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
